// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, reset PC, FSM states,
// RV32 immediate extraction and the 2-bit saturating counter step.
package ifetch_pkg;

  localparam logic [6:0]  OP_JAL       = 7'b1101111;
  localparam logic [6:0]  OP_JALR      = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_PAUSE = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ifetch_bht.sv
// Branch history table: 2^BHT_BITS two-bit counters, combinational read, synchronous update.
// Only built when IFETCH_BHT_EN is defined.
`ifdef IFETCH_BHT_EN
module ifetch_bht
  import ifetch_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                upd,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  logic [1:0] ctr_r [2**BHT_BITS];

  // A same-cycle update is not visible here until the next clock.
  assign rd_ctr = ctr_r[rd_idx];

  // Counter array: weakly not-taken at reset, stepped toward the committed outcome.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**BHT_BITS; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (rdy && upd) begin
      ctr_r[upd_idx] <= ctr_next(ctr_r[upd_idx], upd_taken);
    end
  end

endmodule
`endif

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, I-cache request, next-PC prediction and decoder handshake.
// Define IFETCH_BHT_EN for a dynamic BHT; otherwise branches are backward-taken/forward-not-taken.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        stall,
  input  logic        jalr_need_pause,
  input  logic        jalr_pause_rej,
  input  logic [31:0] jalr_pc,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_data,
  input  logic        bp_upd,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_PC,
  output logic        pred_jump
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic         ic_req_r, ic_req_s;
  logic         inst_rdy_r, inst_rdy_s;
  logic [31:0]  inst_r, inst_s;
  logic [31:0]  inst_pc_r, inst_pc_s;
  logic         pred_jump_r, pred_jump_s;
  logic         kill_r, kill_s;
  logic [31:0]  npc_s;
  logic         pred_s;
  logic         br_taken_s;
  logic         unused_s;

`ifdef IFETCH_BHT_EN
  logic [1:0] bht_ctr_s;

  ifetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rd_idx    (pc_r[BHT_BITS+1:2]),
    .rd_ctr    (bht_ctr_s),
    .upd       (bp_upd),
    .upd_idx   (bp_upd_pc[BHT_BITS+1:2]),
    .upd_taken (bp_upd_taken)
  );

  assign br_taken_s = bht_ctr_s[1];
  assign unused_s   = ^{bht_ctr_s[0], bp_upd_pc[31:BHT_BITS+2], bp_upd_pc[1:0]};
`else
  assign br_taken_s = ic_data[31];
  assign unused_s   = ^{bp_upd, bp_upd_pc, bp_upd_taken};
`endif

  assign ic_req    = ic_req_r;
  assign ic_addr   = pc_r;
  assign inst_rdy  = inst_rdy_r;
  assign inst      = inst_r;
  assign inst_PC   = inst_pc_r;
  assign pred_jump = pred_jump_r;

  // Next-PC prediction for the word currently returned by the cache.
  always_comb begin
    npc_s  = pc_r + 32'd4;
    pred_s = 1'b0;
    case (ic_data[6:0])
      OP_JAL: begin
        npc_s  = pc_r + imm_j(ic_data);
        pred_s = 1'b1;
      end
      OP_BRANCH: begin
        if (br_taken_s) begin
          npc_s  = pc_r + imm_b(ic_data);
          pred_s = 1'b1;
        end else begin
          npc_s  = pc_r + 32'd4;
          pred_s = 1'b0;
        end
      end
      OP_JALR: begin
        npc_s  = pc_r;
        pred_s = 1'b0;
      end
      default: begin
        npc_s  = pc_r + 32'd4;
        pred_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: rollback overrides everything, then the fetch/issue sequence.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ic_req_s    = ic_req_r;
    inst_rdy_s  = inst_rdy_r;
    inst_s      = inst_r;
    inst_pc_s   = inst_pc_r;
    pred_jump_s = pred_jump_r;
    kill_s      = kill_r;
    if (rollback) begin
      state_s    = ST_FETCH;
      pc_s       = rollback_pc;
      ic_req_s   = 1'b0;
      inst_rdy_s = 1'b0;
      // A response still in flight from WAIT must be swallowed when it lands.
      kill_s     = (state_r == ST_WAIT) ? ~ic_valid : (kill_r & ~ic_valid);
    end else begin
      kill_s = kill_r & ~ic_valid;
      case (state_r)
        ST_FETCH: begin
          ic_req_s = 1'b1;
          state_s  = ST_WAIT;
        end
        ST_WAIT: begin
          if (ic_valid && !kill_r) begin
            inst_s      = ic_data;
            inst_pc_s   = pc_r;
            pred_jump_s = pred_s;
            pc_s        = npc_s;
            inst_rdy_s  = 1'b1;
            ic_req_s    = 1'b0;
            state_s     = ST_ISSUE;
          end else begin
            ic_req_s = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (stall) begin
            inst_rdy_s = 1'b1;
          end else if (jalr_need_pause) begin
            state_s = ST_PAUSE;
          end else if (jalr_pause_rej) begin
            pc_s       = jalr_pc;
            inst_rdy_s = 1'b0;
            state_s    = ST_FETCH;
          end else begin
            inst_rdy_s = 1'b0;
            state_s    = ST_FETCH;
          end
        end
        ST_PAUSE: begin
          if (jalr_pause_rej) begin
            pc_s       = jalr_pc;
            inst_rdy_s = 1'b0;
            state_s    = ST_FETCH;
          end else begin
            state_s = ST_PAUSE;
          end
        end
        default: begin
          state_s    = ST_FETCH;
          ic_req_s   = 1'b0;
          inst_rdy_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; rdy=0 freezes everything except reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      ic_req_r    <= 1'b0;
      inst_rdy_r  <= 1'b0;
      inst_r      <= 32'd0;
      inst_pc_r   <= 32'd0;
      pred_jump_r <= 1'b0;
      kill_r      <= 1'b0;
    end else if (rdy) begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ic_req_r    <= ic_req_s;
      inst_rdy_r  <= inst_rdy_s;
      inst_r      <= inst_s;
      inst_pc_r   <= inst_pc_s;
      pred_jump_r <= pred_jump_s;
      kill_r      <= kill_s;
    end
  end

endmodule
